alu_issue: RTL and testbench
============================

# alu_issue

Two-stage issue front end for the single-cycle ALU in the RV32 unicycle datapath. It accepts an instruction word and register operands over a valid/ready handshake, then decodes opcode, funct3 and funct7 into the ALU's 4-bit control code. It drives the control code and operands to the ALU, registers the ALU result with a zero flag, and presents it downstream over a second valid/ready handshake. It also keeps saturating counts of issued and illegal operations.

## Interface
- CNT_W, 16, width of the issue and illegal counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-high
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  stage 1 can accept
- instr  in  32  instruction word
- rs1_val  in  32  rs1 operand
- rs2_val  in  32  rs2 operand
- alu_ctl  out  4  control code to ALU (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT)
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_out  in  32  combinational ALU result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  registered result
- result_zero  out  1  result == 0
- illegal  out  1  the instruction behind result was not decodable
- issue_count  out  CNT_W  accepted instructions, saturating
- illegal_count  out  CNT_W  accepted illegal instructions, saturating

## Operation
- Decode (stage 1 input), opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25]:
  - 0110011 R-type, B = rs2_val:
    - f3 000 with f7 0000000 → 2 (ADD).
    - f3 000 with f7 0100000 → 6 (SUB).
    - f3 111 → 0 (AND); f3 110 → 1 (OR); f3 010 → 7 (SLT). All three require f7 0000000.
  - 0010011 I-type, B = sign-extended instr[31:20]:
    - f3 000 → 2; 111 → 0; 110 → 1; 010 → 7.
  - 1100011 with f3 000 (BEQ) → 6, B = rs2_val.
  - Anything else is illegal: ctl = 4'hF, B = 0, illegal bit set.
- A = rs1_val always. Code 12 (NOR) is never issued.
- SLT semantics are the ALU's: unsigned 32-bit compare.
- Stage 1 registers hold s1_valid, ctl, A, B and illegal. alu_ctl, alu_a and alu_b are driven directly from these registers, so they are stable for the whole cycle.
- Stage 2 registers hold out_valid, result, result_zero and illegal.
  - result = alu_out, or 0 when the instruction is illegal.
  - result_zero = (result == 0), computed locally. The ALU zero output is not used.
- Counters:
  - issue_count increments on every in_valid && in_ready.
  - illegal_count increments on the same condition when the decode is illegal.
  - Both saturate at all-ones.

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, result_zero 0, illegal 0, alu_ctl 4'hF, alu_a 0, alu_b 0, both counters 0, s1_valid 0.
- Handshakes:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready, with no combinational path from in_valid.
- Latency:
  - An instruction accepted at edge N is presented on alu_* during cycle N→N+1.
  - Its result is captured at edge N+1, so out_valid is high from N+1.
  - Throughput is one per cycle when out_ready is held high.
- Backpressure:
  - While out_valid && !out_ready, stage 2 holds and stage 1 holds once full.
  - Held alu_* outputs and result remain bit-stable.
- Simultaneous events:
  - out_ready and in_valid high together on a full pipe: both stages advance in the same edge with no bubble.
  - A stage-2 drain alone: out_valid drops at the next edge.
- Reset mid-operation clears both stages immediately (asynchronous), and in-flight instructions are lost.
- Counter saturation: at all-ones, further accepts leave the value unchanged with no wrap.

## Structure
- A shared package (riscv_pkg) holds:
  - ALU control constants: ALU_AND = 0, ALU_OR = 1, ALU_ADD = 2, ALU_SUB = 6, ALU_SLT = 7, ALU_NOR = 12, ALU_NOP = 15.
  - Opcode constants: OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BR = 7'b1100011.
- One sub-module, alu_decode: combinational instr → {ctl, use_imm, imm, illegal}. It is reused later by the control unit.
- The pipeline registers and counters live in alu_issue.

## Test plan
- Reset: assert reset mid-stream → all outputs at reset values asynchronously, counters 0, in_ready 1.
- ADD stream with out_ready = 1:
  - Stimulus: add (instr 0x002081B3), rs1 = 5, rs2 = 7, then sub (0x402081B3) with the same operands.
  - Required: alu_ctl 2 then 6.
  - Required results: 12 at edge N+1, then 0xFFFFFFFE at edge N+2, with result_zero 0 both times.
- BEQ: instr 0x00208063 with rs1 = rs2 = 0x1234 → alu_ctl 6, result 0, result_zero 1.
- Immediates:
  - addi -1 (0xFFF08093), rs1 = 3 → alu_b 0xFFFFFFFF, result 2.
  - slti -1, rs1 = 3 → alu_ctl 7, result 1 (unsigned).
- Illegal: instr 0x00000073 → alu_ctl 15, result 0, illegal 1, illegal_count increments by 1.
- Backpressure:
  - Setup: out_ready held 0 for 4 cycles while in_valid is high.
  - Required: two accepted, then in_ready 0, with result and alu_* stable.
  - Release: on release, results drain in order with no loss or duplication.
  - Count: issue_count equals the number of handshakes.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 constants: ALU control codes and the major opcodes the issue stage decodes.
package riscv_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an RV32 instruction into the ALU control code,
// the operand-B source select and the sign-extended I-type immediate.
module alu_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  ctl,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign imm           = {{20{instr[31]}}, instr[31:20]};
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  // NOTE: every output gets a default before the case tree, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    ctl     = ALU_NOP;
    use_imm = 1'b0;
    illegal = 1'b1;
    unique case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000:  begin ctl = ALU_ADD; illegal = 1'b0; end
            3'b111:  begin ctl = ALU_AND; illegal = 1'b0; end
            3'b110:  begin ctl = ALU_OR;  illegal = 1'b0; end
            3'b010:  begin ctl = ALU_SLT; illegal = 1'b0; end
            default: ;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          ctl     = ALU_SUB;
          illegal = 1'b0;
        end
      end
      OP_I: begin
        use_imm = 1'b1;
        unique case (funct3)
          3'b000:  begin ctl = ALU_ADD; illegal = 1'b0; end
          3'b111:  begin ctl = ALU_AND; illegal = 1'b0; end
          3'b110:  begin ctl = ALU_OR;  illegal = 1'b0; end
          3'b010:  begin ctl = ALU_SLT; illegal = 1'b0; end
          default: use_imm = 1'b0;
        endcase
      end
      OP_BR: begin
        if (funct3 == 3'b000) begin
          ctl     = ALU_SUB;
          illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue front end for the single-cycle ALU: stage 1 holds the decoded
// operation driving the ALU, stage 2 captures the result for a valid/ready consumer.
module alu_issue
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  output logic [3:0]       alu_ctl,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             result_zero,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]  dec_ctl;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic [31:0] dec_b;

  logic        s1_valid;
  logic        s1_illegal;
  logic        s2_load;
  logic        accept;
  logic [31:0] s2_result;

  alu_decode u_decode (
    .instr   (instr),
    .ctl     (dec_ctl),
    .use_imm (dec_use_imm),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign dec_b     = dec_illegal ? '0 : (dec_use_imm ? dec_imm : rs2_val);
  assign s2_load   = s1_valid && (!out_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign accept    = in_valid && in_ready;
  assign s2_result = s1_illegal ? '0 : alu_out;

  // Operand registers only load on accept, so alu_* stay bit-stable under backpressure.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      alu_ctl    <= ALU_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_illegal <= dec_illegal;
      alu_ctl    <= dec_ctl;
      alu_a      <= rs1_val;
      alu_b      <= dec_b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      result      <= '0;
      result_zero <= 1'b0;
      illegal     <= 1'b0;
    end else if (s2_load) begin
      out_valid   <= 1'b1;
      result      <= s2_result;
      result_zero <= (s2_result == '0);
      illegal     <= s1_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count   <= '0;
      illegal_count <= '0;
    end else if (accept) begin
      if (issue_count != '1)                   issue_count   <= issue_count + CNT_ONE;
      if (dec_illegal && illegal_count != '1) illegal_count <= illegal_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU closing the loop;
// counters are narrowed so saturation is reachable in a few cycles.
module tb_alu_issue;

  localparam int CNT_W = 4;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_ADDI = 32'hFFF08093;
  localparam logic [31:0] I_SLTI = 32'hFFF0A093;
  localparam logic [31:0] I_ILL  = 32'h00000073;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      rs1_val;
  logic [31:0]      rs2_val;
  logic [3:0]       alu_ctl;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_out;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic             result_zero;
  logic             illegal;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] illegal_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .alu_ctl       (alu_ctl),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_out       (alu_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .result_zero   (result_zero),
    .illegal       (illegal),
    .issue_count   (issue_count),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; unknown codes yield a non-zero pattern so illegal forcing is visible.
  always_comb begin
    alu_out = 32'hDEADBEEF;
    case (alu_ctl)
      4'd0:  alu_out = alu_a & alu_b;
      4'd1:  alu_out = alu_a | alu_b;
      4'd2:  alu_out = alu_a + alu_b;
      4'd6:  alu_out = alu_a - alu_b;
      4'd7:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'd12: alu_out = ~(alu_a | alu_b);
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = v;
    instr    = i;
    rs1_val  = a;
    rs2_val  = b;
  endtask

  initial begin
    logic [31:0] bp_a [3];
    logic [31:0] bp_b [3];
    logic        bp_rdy [4];
    int          k;
    bp_a   = '{32'd10, 32'd20, 32'd30};
    bp_b   = '{32'd1, 32'd2, 32'd3};
    bp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};

    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(result_zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_ctl", 32'(alu_ctl), 32'hF);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_issue_cnt", 32'(issue_count), 32'd0);
    check("rst_ill_cnt", 32'(illegal_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back add/sub with the consumer always ready.
    out_ready = 1'b1;
    drive(1'b1, I_ADD, 32'd5, 32'd7);
    tick();
    check("add_ctl", 32'(alu_ctl), 32'd2);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_ov_early", 32'(out_valid), 32'd0);
    drive(1'b1, I_SUB, 32'd5, 32'd7);
    tick();
    check("add_ov", 32'(out_valid), 32'd1);
    check("add_res", result, 32'd12);
    check("add_zero", 32'(result_zero), 32'd0);
    check("sub_ctl", 32'(alu_ctl), 32'd6);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("sub_res", result, 32'hFFFFFFFE);
    check("sub_zero", 32'(result_zero), 32'd0);
    check("sub_ov", 32'(out_valid), 32'd1);
    tick();
    check("drain_ov", 32'(out_valid), 32'd0);

    drive(1'b1, I_BEQ, 32'h1234, 32'h1234);
    tick();
    check("beq_ctl", 32'(alu_ctl), 32'd6);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("beq_res", result, 32'd0);
    check("beq_zero", 32'(result_zero), 32'd1);

    drive(1'b1, I_ADDI, 32'd3, 32'h55);
    tick();
    check("addi_b", alu_b, 32'hFFFFFFFF);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("addi_res", result, 32'd2);

    drive(1'b1, I_SLTI, 32'd3, 32'd0);
    tick();
    check("slti_ctl", 32'(alu_ctl), 32'd7);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("slti_res", result, 32'd1);

    drive(1'b1, I_ILL, 32'd9, 32'd9);
    tick();
    check("ill_ctl", 32'(alu_ctl), 32'hF);
    check("ill_b", alu_b, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("ill_res", result, 32'd0);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_cnt", 32'(illegal_count), 32'd1);
    check("issue_cnt6", 32'(issue_count), 32'd6);
    tick();

    // Consumer stalls for four cycles with a producer that never lets up.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, I_ADD, bp_a[k], bp_b[k]);
      #1;
      check($sformatf("bp_ready%0d", c), 32'(in_ready), 32'(bp_rdy[c]));
      if (bp_rdy[c]) k++;
      tick();
      if (c >= 1) begin
        check($sformatf("bp_ov%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("bp_res%0d", c), result, 32'd11);
        check($sformatf("bp_a%0d", c), alu_a, 32'd20);
        check($sformatf("bp_b%0d", c), alu_b, 32'd2);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b1;
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);
    tick();
    check("rel_ov1", 32'(out_valid), 32'd1);
    check("rel_res1", result, 32'd22);
    tick();
    check("rel_ov2", 32'(out_valid), 32'd0);
    check("bp_issue_cnt", 32'(issue_count), 32'd8);
    check("bp_ill_cnt", 32'(illegal_count), 32'd1);

    // Asynchronous reset with both stages occupied.
    drive(1'b1, I_ADD, 32'd1, 32'd1);
    tick();
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_res", result, 32'd0);
    check("mrst_ctl", 32'(alu_ctl), 32'hF);
    check("mrst_a", alu_a, 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    check("mrst_issue_cnt", 32'(issue_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Counter saturation at 4'hF.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, I_ILL, 32'd0, 32'd0);
      tick();
      if (i == 9) begin
        check("sat_issue10", 32'(issue_count), 32'd10);
        check("sat_ill10", 32'(illegal_count), 32'd10);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("sat_issue", 32'(issue_count), 32'd15);
    check("sat_ill", 32'(illegal_count), 32'd15);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
